// File: rtl/axi_ar_arbiter.sv
// axi_ar_arbiter: AR-channel arbiter/router for the 2-master x 3-slave AXI interconnect.
// Arbitrates M0/M1 read-address requests, decodes ARADDR to S0/S1/DEFAULT, and prefixes
// the master index onto ARID so the R return mux can route data back. Each master may
// have one read burst outstanding; its flag clears on the master-side RLAST handshake.
// Optional feature macro: AR_RR_EN (round-robin tie-breaking instead of fixed M0 > M1).
//
// Handshake rule: a transfer happens on a rising ACLK edge where VALID and READY are both
// high. The master-side ARREADY is a same-cycle combinational grant in IDLE. The slave-side
// ARVALID is driven from registers only and, once high, stays high with a stable payload
// until the addressed slave returns ARREADY.
module axi_ar_arbiter #(
    parameter int          ID_BITS   = 4,
    parameter int          IDS_BITS  = 8,
    parameter int          ADDR_BITS = 32,
    parameter logic [31:0] S0_BASE   = 32'h0000_0000,
    parameter logic [31:0] S1_BASE   = 32'h0001_0000
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    // master 0 AR
    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [3:0]           ARLEN_M0,
    input  logic [2:0]           ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    // master 1 AR
    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [3:0]           ARLEN_M1,
    input  logic [2:0]           ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    // master-side R-channel monitor taps
    input  logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    input  logic                 RLAST_M0,
    input  logic                 RVALID_M1,
    input  logic                 RREADY_M1,
    input  logic                 RLAST_M1,
    // shared slave-side payload
    output logic [IDS_BITS-1:0]  ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [3:0]           ARLEN_S,
    output logic [2:0]           ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    // one-hot slave requests
    output logic                 ARVALID_S0,
    output logic                 ARVALID_S1,
    output logic                 ARVALID_DEFAULT,
    input  logic                 ARREADY_S0,
    input  logic                 ARREADY_S1,
    input  logic                 ARREADY_DEFAULT,
    // debug taps: FSM state (0=IDLE, 1=ISSUE) and outstanding flags {OUT_M1, OUT_M0}
    output logic                 o_dbg_state,
    output logic [1:0]           o_dbg_out
);

    localparam int IDX_W = IDS_BITS - ID_BITS;
    localparam logic [IDX_W-1:0] IDX_M0 = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_M1 = IDX_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_S0  = 2'd0,
        SEL_S1  = 2'd1,
        SEL_DEF = 2'd2
    } sel_t;

    state_t               r_state;
    state_t               w_state_nxt;
    sel_t                 r_sel;
    logic                 r_out_m0;
    logic                 r_out_m1;
    logic [IDS_BITS-1:0]  r_arid;
    logic [ADDR_BITS-1:0] r_araddr;
    logic [3:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic [1:0]           r_arburst;

    logic                 w_req0;
    logic                 w_req1;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_capture;
    logic                 w_rlast_hs0;
    logic                 w_rlast_hs1;
    logic [IDS_BITS-1:0]  w_cap_id;
    logic [ADDR_BITS-1:0] w_cap_addr;
    logic [3:0]           w_cap_len;
    logic [2:0]           w_cap_size;
    logic [1:0]           w_cap_burst;
    sel_t                 w_cap_sel;

    // Address decode on the 64 KiB region index; anything unmatched goes to DEFAULT.
    function automatic sel_t decode(input logic [ADDR_BITS-1:0] addr);
        if (addr[31:16] == S0_BASE[31:16]) begin
            return SEL_S0;
        end else if (addr[31:16] == S1_BASE[31:16]) begin
            return SEL_S1;
        end else begin
            return SEL_DEF;
        end
    endfunction

    // A master with a burst already outstanding is not eligible.
    assign w_req0 = ARVALID_M0 & ~r_out_m0;
    assign w_req1 = ARVALID_M1 & ~r_out_m1;

    assign w_rlast_hs0 = RVALID_M0 & RREADY_M0 & RLAST_M0;
    assign w_rlast_hs1 = RVALID_M1 & RREADY_M1 & RLAST_M1;

`ifdef AR_RR_EN
    // Index of the most recently captured master; reset to 1 so M0 wins the first tie.
    logic r_last_gnt;

    // On a tie the master that was not granted last time wins.
    assign w_gnt0 = w_req0 & (~w_req1 | r_last_gnt);
    assign w_gnt1 = w_req1 & (~w_req0 | ~r_last_gnt);

    // Remember the winner of every capture for the next tie-break.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last_gnt <= 1'b1;
        end else if (w_capture) begin
            r_last_gnt <= ARREADY_M1;
        end
    end
`else
    // Fixed priority: M0 always beats M1.
    assign w_gnt0 = w_req0;
    assign w_gnt1 = w_req1 & ~w_req0;
`endif

    // Select the winning master's payload and prefix its index onto the ID.
    always_comb begin
        w_cap_id    = {IDX_M0, ARID_M0};
        w_cap_addr  = ARADDR_M0;
        w_cap_len   = ARLEN_M0;
        w_cap_size  = ARSIZE_M0;
        w_cap_burst = ARBURST_M0;
        if (w_gnt1) begin
            w_cap_id    = {IDX_M1, ARID_M1};
            w_cap_addr  = ARADDR_M1;
            w_cap_len   = ARLEN_M1;
            w_cap_size  = ARSIZE_M1;
            w_cap_burst = ARBURST_M1;
        end
        w_cap_sel = decode(w_cap_addr);
    end

    // Next-state and handshake outputs: grant in IDLE, hold the slave request in ISSUE.
    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        ARREADY_M0      = 1'b0;
        ARREADY_M1      = 1'b0;
        ARVALID_S0      = 1'b0;
        ARVALID_S1      = 1'b0;
        ARVALID_DEFAULT = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ARREADY_M0 = w_gnt0;
                ARREADY_M1 = w_gnt1;
                if (w_gnt0 | w_gnt1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (r_sel)
                    SEL_S0: begin
                        ARVALID_S0 = 1'b1;
                        if (ARREADY_S0) w_state_nxt = ST_IDLE;
                    end
                    SEL_S1: begin
                        ARVALID_S1 = 1'b1;
                        if (ARREADY_S1) w_state_nxt = ST_IDLE;
                    end
                    SEL_DEF: begin
                        ARVALID_DEFAULT = 1'b1;
                        if (ARREADY_DEFAULT) w_state_nxt = ST_IDLE;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload capture register; held unchanged until the next capture.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_sel     <= SEL_S0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else if (w_capture) begin
            r_sel     <= w_cap_sel;
            r_arid    <= w_cap_id;
            r_araddr  <= w_cap_addr;
            r_arlen   <= w_cap_len;
            r_arsize  <= w_cap_size;
            r_arburst <= w_cap_burst;
        end
    end

    // Outstanding flags: set on grant, cleared by RLAST handshake. A set needs the flag
    // low and a clear only matters with it high, so the two never collide.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_out_m0 <= 1'b0;
            r_out_m1 <= 1'b0;
        end else begin
            if (ARREADY_M0) begin
                r_out_m0 <= 1'b1;
            end else if (w_rlast_hs0) begin
                r_out_m0 <= 1'b0;
            end
            if (ARREADY_M1) begin
                r_out_m1 <= 1'b1;
            end else if (w_rlast_hs1) begin
                r_out_m1 <= 1'b0;
            end
        end
    end

    assign ARID_S      = r_arid;
    assign ARADDR_S    = r_araddr;
    assign ARLEN_S     = r_arlen;
    assign ARSIZE_S    = r_arsize;
    assign ARBURST_S   = r_arburst;
    assign o_dbg_state = r_state;
    assign o_dbg_out   = {r_out_m1, r_out_m0};

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// tb_axi_ar_arbiter: directed vector table, a reset-in-ISSUE sequence and a randomized
// run against a transaction-level reference model of the AR arbiter.
module tb_axi_ar_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic        RVALID_M0, RREADY_M0, RLAST_M0;
  logic        RVALID_M1, RREADY_M1, RLAST_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S0, ARVALID_S1, ARVALID_DEFAULT;
  logic        ARREADY_S0, ARREADY_S1, ARREADY_DEFAULT;
  logic        dbg_state;
  logic [1:0]  dbg_out;

  int n_checks = 0;
  int n_pass = 0;

`ifdef AR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  axi_ar_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1), .RLAST_M1(RLAST_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S),
    .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1), .ARVALID_DEFAULT(ARVALID_DEFAULT),
    .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1), .ARREADY_DEFAULT(ARREADY_DEFAULT),
    .o_dbg_state(dbg_state), .o_dbg_out(dbg_out)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    ARID_M0 = '0; ARID_M1 = '0; ARADDR_M0 = '0; ARADDR_M1 = '0;
    ARLEN_M0 = 4'h3; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    ARLEN_M1 = 4'h7; ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'd2;
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    RVALID_M0 = 1'b0; RREADY_M0 = 1'b0; RLAST_M0 = 1'b0;
    RVALID_M1 = 1'b0; RREADY_M1 = 1'b0; RLAST_M1 = 1'b0;
    ARREADY_S0 = 1'b0; ARREADY_S1 = 1'b0; ARREADY_DEFAULT = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    drive_idle();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  // sready / e_vs bit order: [0]=S0, [1]=S1, [2]=DEFAULT. hs: full RLAST handshake per master.
  typedef struct {
    logic [1:0]  vld;
    logic [31:0] a0, a1;
    logic [3:0]  id0, id1;
    logic [2:0]  sready;
    logic [1:0]  hs;
    logic [1:0]  e_rdy;
    logic [2:0]  e_vs;
    logic [7:0]  e_id;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [3:0] id0, input logic [3:0] id1, input logic [2:0] sready,
                              input logic [1:0] hs, input logic [1:0] e_rdy, input logic [2:0] e_vs,
                              input logic [7:0] e_id, input logic [31:0] e_addr);
    vec_t v;
    v.vld = vld; v.a0 = a0; v.a1 = a1; v.id0 = id0; v.id1 = id1; v.sready = sready;
    v.hs = hs; v.e_rdy = e_rdy; v.e_vs = e_vs; v.e_id = e_id; v.e_addr = e_addr;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic build_table();
    logic [31:0] A0, A1, A2, A3, A4;
    // second tie: fixed re-grants M0 (its flag was cleared), round-robin alternates to M1
    logic [1:0]  t2_rdy, t3_rdy;
    logic [2:0]  t2_vs, t3_vs;
    logic [7:0]  t2_id, t3_id;
    logic [31:0] t2_ad, t3_ad;
    A0 = 32'h0000_0040; A1 = 32'h0001_0010; A2 = 32'h2000_0000;
    A3 = 32'h0000_0100; A4 = 32'h0001_0020;
    t2_rdy = RR ? 2'b10 : 2'b01;
    t2_vs  = RR ? 3'b010 : 3'b001;
    t2_id  = RR ? 8'h12 : 8'h01;
    t2_ad  = RR ? A4 : A3;
    t3_rdy = RR ? 2'b01 : 2'b10;
    t3_vs  = RR ? 3'b001 : 3'b010;
    t3_id  = RR ? 8'h01 : 8'h12;
    t3_ad  = RR ? A3 : A4;
    //            vld    a0  a1  id0  id1 sready  hs     e_rdy  e_vs    e_id   e_addr
    vecs.push_back(mk(2'b00, 0,  0,  0,   0, 3'b000, 2'b00, 2'b00, 3'b000, 8'h00, 0));
    vecs.push_back(mk(2'b01, A0, 0,  3,   0, 3'b000, 2'b00, 2'b01, 3'b000, 8'h00, 0));
    vecs.push_back(mk(2'b00, A0, 0,  3,   0, 3'b000, 2'b00, 2'b00, 3'b001, 8'h03, A0));
    vecs.push_back(mk(2'b00, A0, 0,  3,   0, 3'b000, 2'b00, 2'b00, 3'b001, 8'h03, A0));
    vecs.push_back(mk(2'b00, A0, 0,  3,   0, 3'b001, 2'b00, 2'b00, 3'b001, 8'h03, A0));
    vecs.push_back(mk(2'b10, A0, A1, 3,   5, 3'b000, 2'b00, 2'b10, 3'b000, 8'h03, A0));
    vecs.push_back(mk(2'b00, A0, A1, 3,   5, 3'b010, 2'b00, 2'b00, 3'b010, 8'h15, A1));
    vecs.push_back(mk(2'b10, A0, A2, 3,   5, 3'b000, 2'b10, 2'b00, 3'b000, 8'h15, A1));
    vecs.push_back(mk(2'b10, A0, A2, 3,   5, 3'b000, 2'b00, 2'b10, 3'b000, 8'h15, A1));
    vecs.push_back(mk(2'b00, A0, A2, 3,   5, 3'b100, 2'b00, 2'b00, 3'b100, 8'h15, A2));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b000, 2'b11, 2'b00, 3'b000, 8'h15, A2));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b000, 2'b00, 2'b01, 3'b000, 8'h15, A2));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b001, 2'b01, 2'b00, 3'b001, 8'h01, A3));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b000, 2'b00, t2_rdy, 3'b000, 8'h01, A3));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b111, 2'b00, 2'b00, t2_vs, t2_id, t2_ad));
    vecs.push_back(mk(2'b11, A3, A4, 1,   2, 3'b000, 2'b00, t3_rdy, 3'b000, t2_id, t2_ad));
    vecs.push_back(mk(2'b00, A3, A4, 1,   2, 3'b111, 2'b00, 2'b00, t3_vs, t3_id, t3_ad));
    vecs.push_back(mk(2'b00, A3, A4, 1,   2, 3'b000, 2'b10, 2'b00, 3'b000, t3_id, t3_ad));
    vecs.push_back(mk(2'b00, A3, A4, 1,   2, 3'b000, 2'b10, 2'b00, 3'b000, t3_id, t3_ad));
    vecs.push_back(mk(2'b10, A3, A2, 1,   5, 3'b000, 2'b00, 2'b10, 3'b000, t3_id, t3_ad));
    vecs.push_back(mk(2'b00, A3, A2, 1,   5, 3'b100, 2'b00, 2'b00, 3'b100, 8'h15, A2));
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge ACLK);
      ARVALID_M0 = vecs[i].vld[0]; ARVALID_M1 = vecs[i].vld[1];
      ARADDR_M0 = vecs[i].a0; ARADDR_M1 = vecs[i].a1;
      ARID_M0 = vecs[i].id0; ARID_M1 = vecs[i].id1;
      ARREADY_S0 = vecs[i].sready[0]; ARREADY_S1 = vecs[i].sready[1];
      ARREADY_DEFAULT = vecs[i].sready[2];
      {RVALID_M0, RREADY_M0, RLAST_M0} = {3{vecs[i].hs[0]}};
      {RVALID_M1, RREADY_M1, RLAST_M1} = {3{vecs[i].hs[1]}};
      #1;
      check($sformatf("vec%0d_arready", i), {ARREADY_M1, ARREADY_M0}, vecs[i].e_rdy);
      check($sformatf("vec%0d_arvalid_s", i), {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, vecs[i].e_vs);
      check($sformatf("vec%0d_arid_s", i), ARID_S, vecs[i].e_id);
      check($sformatf("vec%0d_araddr_s", i), ARADDR_S, vecs[i].e_addr);
    end
  endtask

  // ---------------- reset asserted during ISSUE ----------------
  task automatic run_reset_in_issue();
    do_reset();
    @(negedge ACLK);
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0004; ARID_M1 = 4'h9;
    #1;
    check("rst_pre_grant", ARREADY_M1, 1'b1);
    @(negedge ACLK);
    ARVALID_M1 = 1'b0;
    #1;
    check("rst_pre_issue_s1", {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, 3'b010);
    check("rst_pre_issue_id", ARID_S, 8'h19);
    ARESETn = 1'b0;
    #1;
    check("rst_async_vs", {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, 3'b000);
    check("rst_async_out", dbg_out, 2'b00);
    check("rst_async_state", dbg_state, 1'b0);
    check("rst_async_id", ARID_S, 8'h00);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0008; ARID_M1 = 4'h2;
    #1;
    check("rst_post_grant", {ARREADY_M1, ARREADY_M0}, 2'b10);
    @(negedge ACLK);
    ARVALID_M1 = 1'b0; ARREADY_S1 = 1'b1;
    #1;
    check("rst_post_issue", {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, 3'b010);
    check("rst_post_id", ARID_S, 8'h12);
    @(negedge ACLK);
    ARREADY_S1 = 1'b0;
    #1;
    check("rst_post_idle", {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, 3'b000);
  endtask

  // ---------------- randomized run with reference model ----------------
  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          slv;
  } ar_t;

  function automatic int slave_of(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a[15:0] = 16'($urandom);
    case ($urandom_range(0, 2))
      0: a[31:16] = 16'h0000;
      1: a[31:16] = 16'h0001;
      default: a[31:16] = 16'($urandom_range(2, 65535));
    endcase
    return a;
  endfunction

  task automatic run_random(input int cycles);
    ar_t  pend_q[$];
    ar_t  last_cap;
    ar_t  cap;
    bit   m_out[2];
    int   m_last;
    int   winner;
    bit   vld[2];
    bit   hs[2];
    logic [2:0] srdy;
    logic [1:0] e_rdy;
    logic [2:0] e_vs;
    do_reset();
    last_cap = '{id: 8'h00, addr: 32'h0, len: 4'h0, size: 3'h0, burst: 2'h0, slv: 0};
    m_out[0] = 1'b0; m_out[1] = 1'b0;
    m_last = 1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge ACLK);
      ARVALID_M0 = 1'($urandom_range(0, 1)); ARVALID_M1 = 1'($urandom_range(0, 1));
      ARADDR_M0 = rand_addr(); ARADDR_M1 = rand_addr();
      ARID_M0 = 4'($urandom); ARID_M1 = 4'($urandom);
      ARLEN_M0 = 4'($urandom); ARLEN_M1 = 4'($urandom);
      ARSIZE_M0 = 3'($urandom); ARSIZE_M1 = 3'($urandom);
      ARBURST_M0 = 2'($urandom); ARBURST_M1 = 2'($urandom);
      srdy = 3'($urandom);
      {ARREADY_DEFAULT, ARREADY_S1, ARREADY_S0} = srdy;
      RVALID_M0 = 1'($urandom_range(0, 1)); RREADY_M0 = 1'($urandom_range(0, 1));
      RLAST_M0 = 1'($urandom_range(0, 1));
      RVALID_M1 = 1'($urandom_range(0, 1)); RREADY_M1 = 1'($urandom_range(0, 1));
      RLAST_M1 = 1'($urandom_range(0, 1));
      vld[0] = ARVALID_M0; vld[1] = ARVALID_M1;
      hs[0] = RVALID_M0 & RREADY_M0 & RLAST_M0;
      hs[1] = RVALID_M1 & RREADY_M1 & RLAST_M1;
      #1;
      // expected outputs for this cycle
      winner = -1;
      e_rdy = 2'b00;
      e_vs = 3'b000;
      if (pend_q.size() > 0) begin
        e_vs[pend_q[0].slv] = 1'b1;
      end else begin
        if (vld[0] && !m_out[0] && vld[1] && !m_out[1]) winner = RR ? 1 - m_last : 0;
        else if (vld[0] && !m_out[0]) winner = 0;
        else if (vld[1] && !m_out[1]) winner = 1;
        if (winner >= 0) e_rdy[winner] = 1'b1;
      end
      check($sformatf("rnd%0d_arready", c), {ARREADY_M1, ARREADY_M0}, e_rdy);
      check($sformatf("rnd%0d_arvalid_s", c), {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, e_vs);
      check($sformatf("rnd%0d_arid_s", c), ARID_S, last_cap.id);
      check($sformatf("rnd%0d_araddr_s", c), ARADDR_S, last_cap.addr);
      check($sformatf("rnd%0d_attr_s", c), {ARLEN_S, ARSIZE_S, ARBURST_S},
            {last_cap.len, last_cap.size, last_cap.burst});
      // advance the model across the coming clock edge
      for (int m = 0; m < 2; m++) begin
        if (hs[m] && m_out[m]) m_out[m] = 1'b0;
      end
      if (pend_q.size() > 0) begin
        if (srdy[pend_q[0].slv]) void'(pend_q.pop_front());
      end else if (winner >= 0) begin
        cap.id    = (winner == 0) ? {4'h0, ARID_M0} : {4'h1, ARID_M1};
        cap.addr  = (winner == 0) ? ARADDR_M0 : ARADDR_M1;
        cap.len   = (winner == 0) ? ARLEN_M0 : ARLEN_M1;
        cap.size  = (winner == 0) ? ARSIZE_M0 : ARSIZE_M1;
        cap.burst = (winner == 0) ? ARBURST_M0 : ARBURST_M1;
        cap.slv   = slave_of(cap.addr);
        pend_q.push_back(cap);
        last_cap = cap;
        m_out[winner] = 1'b1;
        m_last = winner;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    ARESETn = 1'b0;
    #1;
    check("reset_arready", {ARREADY_M1, ARREADY_M0}, 2'b00);
    check("reset_arvalid_s", {ARVALID_DEFAULT, ARVALID_S1, ARVALID_S0}, 3'b000);
    check("reset_out", dbg_out, 2'b00);
    check("reset_payload", {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}, 49'h0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    build_table();
    run_table();
    run_reset_in_issue();
    run_random(600);
    @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
